// File: rtl/m1_image_loader.sv
// ---------------------------------------------------------------------------
// m1_image_loader
//
// Upstream stage of the histogram-equalisation accelerator. Accepts a raster
// stream of pixels over a valid/ready handshake, packs PIXELS_PER_WORD pixels
// per M1 word (first pixel in the least-significant lane) and writes the words
// sequentially into M1 from address 0. After a complete frame the accelerator
// start input is pulsed. A frame terminated early by pix_last is flushed
// (partial word zero-padded) and flagged with short_frame instead.
//
// Ports:
//   clock            system clock, rising edge
//   reset            synchronous active-high reset
//   load_go          one-cycle request to load a frame (honoured in IDLE only)
//   pix_valid        pixel present on pix_data
//   pix_data         pixel value
//   pix_last         final pixel of the frame (qualified by pix_valid)
//   pix_ready        loader accepts a pixel this cycle (LOAD state)
//   M1_WriteBus      packed pixel word
//   M1_WriteAddress  word address
//   M1_WriteEnable   one-cycle write strobe per word
//   accel_start      one-cycle start pulse to the accelerator
//   load_done        frame finished (success or error), held until next load_go
//   short_frame      frame ended early, held until next load_go
// ---------------------------------------------------------------------------
module m1_image_loader #(
    parameter int PIXEL_W         = 8,
    parameter int PIXELS_PER_WORD = 16,
    parameter int ADDR_W          = 16,
    parameter int IMAGE_WORDS     = 1024
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               load_go,
    input  logic                               pix_valid,
    input  logic [PIXEL_W-1:0]                 pix_data,
    input  logic                               pix_last,
    output logic                               pix_ready,
    output logic [PIXEL_W*PIXELS_PER_WORD-1:0] M1_WriteBus,
    output logic [ADDR_W-1:0]                  M1_WriteAddress,
    output logic                               M1_WriteEnable,
    output logic                               accel_start,
    output logic                               load_done,
    output logic                               short_frame
);

    localparam int WORD_W = PIXEL_W * PIXELS_PER_WORD;
    localparam int LANE_W = $clog2(PIXELS_PER_WORD);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIXELS_PER_WORD - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(IMAGE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_WAIT,
        S_START,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [ADDR_W-1:0]   word_q, word_d;
    logic [WORD_W-1:0]   pack_q, pack_d;
    logic [WORD_W-1:0]   bus_q, bus_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic                accel_start_q, accel_start_d;
    logic                load_done_q, load_done_d;
    logic                short_frame_q, short_frame_d;

    logic                xfer;
    logic [WORD_W-1:0]   packed_word;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            lane_q        <= '0;
            word_q        <= '0;
            pack_q        <= '0;
            bus_q         <= '0;
            addr_q        <= '0;
            we_q          <= 1'b0;
            accel_start_q <= 1'b0;
            load_done_q   <= 1'b0;
            short_frame_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lane_q        <= lane_d;
            word_q        <= word_d;
            pack_q        <= pack_d;
            bus_q         <= bus_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            accel_start_q <= accel_start_d;
            load_done_q   <= load_done_d;
            short_frame_q <= short_frame_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        lane_d        = lane_q;
        word_d        = word_q;
        pack_d        = pack_q;
        bus_d         = bus_q;
        addr_d        = addr_q;
        we_d          = 1'b0;
        accel_start_d = 1'b0;
        load_done_d   = load_done_q;
        short_frame_d = short_frame_q;

        xfer = pix_valid && (state_q == S_LOAD);

        // Packing register with the incoming pixel dropped into its lane.
        packed_word = pack_q;
        for (int unsigned k = 0; k < PIXELS_PER_WORD; k++) begin
            if (lane_q == LANE_W'(k)) begin
                packed_word[k*PIXEL_W +: PIXEL_W] = pix_data;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (load_go) begin
                    state_d       = S_LOAD;
                    load_done_d   = 1'b0;
                    short_frame_d = 1'b0;
                    lane_d        = '0;
                    word_d        = '0;
                    pack_d        = '0;
                end
            end

            S_LOAD: begin
                if (xfer) begin
                    if (lane_q == LAST_LANE) begin
                        // Word completes: register it for write next cycle
                        // and clear the packer so it is reused immediately.
                        bus_d  = packed_word;
                        addr_d = word_q;
                        we_d   = 1'b1;
                        word_d = word_q + ADDR_W'(1);
                        lane_d = '0;
                        pack_d = '0;
                        if (word_q == LAST_WORD) begin
                            state_d = S_WAIT;
                        end else if (pix_last) begin
                            // Early end on a word boundary: this write is
                            // the flush, FLUSH sees lane 0 and adds nothing.
                            state_d = S_FLUSH;
                        end
                    end else begin
                        pack_d = packed_word;
                        lane_d = lane_q + LANE_W'(1);
                        if (pix_last) begin
                            state_d = S_FLUSH;
                        end
                    end
                end
            end

            S_FLUSH: begin
                if (lane_q != '0) begin
                    bus_d  = pack_q;
                    addr_d = word_q;
                    we_d   = 1'b1;
                end
                state_d       = S_DONE;
                short_frame_d = 1'b1;
                load_done_d   = 1'b1;
            end

            S_WAIT: begin
                state_d       = S_START;
                accel_start_d = 1'b1;
            end

            S_START: begin
                state_d     = S_DONE;
                load_done_d = 1'b1;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pix_ready       = (state_q == S_LOAD);
    assign M1_WriteBus     = bus_q;
    assign M1_WriteAddress = addr_q;
    assign M1_WriteEnable  = we_q;
    assign accel_start     = accel_start_q;
    assign load_done       = load_done_q;
    assign short_frame     = short_frame_q;

endmodule

// File: tb/tb_m1_image_loader.sv
// ---------------------------------------------------------------------------
// tb_m1_image_loader
//
// Self-checking bench for m1_image_loader. Pixels sent and their transfer
// cycles are recorded; expected M1 words, addresses, write cycles and the
// start pulse are derived from that pixel list and compared with what a
// negedge monitor captures from the DUT.
// ---------------------------------------------------------------------------
module tb_m1_image_loader;

    localparam int PIXEL_W     = 8;
    localparam int PPW         = 16;
    localparam int ADDR_W      = 16;
    localparam int IMAGE_WORDS = 1024;
    localparam int NPIX        = PPW * IMAGE_WORDS;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               load_go = 1'b0;
    logic               pix_valid = 1'b0;
    logic [7:0]         pix_data = '0;
    logic               pix_last = 1'b0;
    logic               pix_ready;
    logic [127:0]       M1_WriteBus;
    logic [ADDR_W-1:0]  M1_WriteAddress;
    logic               M1_WriteEnable;
    logic               accel_start;
    logic               load_done;
    logic               short_frame;

    m1_image_loader #(
        .PIXEL_W(PIXEL_W),
        .PIXELS_PER_WORD(PPW),
        .ADDR_W(ADDR_W),
        .IMAGE_WORDS(IMAGE_WORDS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .load_go(load_go),
        .pix_valid(pix_valid),
        .pix_data(pix_data),
        .pix_last(pix_last),
        .pix_ready(pix_ready),
        .M1_WriteBus(M1_WriteBus),
        .M1_WriteAddress(M1_WriteAddress),
        .M1_WriteEnable(M1_WriteEnable),
        .accel_start(accel_start),
        .load_done(load_done),
        .short_frame(short_frame)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor
    logic [ADDR_W-1:0] mon_addr[$];
    logic [127:0]      mon_data[$];
    int                mon_cyc[$];
    int                start_cyc[$];

    always @(negedge clock) begin
        if (M1_WriteEnable) begin
            mon_addr.push_back(M1_WriteAddress);
            mon_data.push_back(M1_WriteBus);
            mon_cyc.push_back(cyc);
        end
        if (accel_start) start_cyc.push_back(cyc);
    end

    // Reference record: pixels accepted and the cycle each transfer occurred
    logic [7:0] px[$];
    int         xfer[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, 128'(pix_ready), 128'(0));
        check({tag, "_we"},    128'(M1_WriteEnable), 128'(0));
        check({tag, "_bus"},   M1_WriteBus, 128'(0));
        check({tag, "_addr"},  128'(M1_WriteAddress), 128'(0));
        check({tag, "_start"}, 128'(accel_start), 128'(0));
        check({tag, "_done"},  128'(load_done), 128'(0));
        check({tag, "_short"}, 128'(short_frame), 128'(0));
    endtask

    task automatic clear_record();
        mon_addr.delete();
        mon_data.delete();
        mon_cyc.delete();
        start_cyc.delete();
        px.delete();
        xfer.delete();
    endtask

    task automatic start_frame();
        clear_record();
        @(posedge clock); #1;
        load_go = 1'b1;
        @(posedge clock); #1;
        load_go = 1'b0;
    endtask

    task automatic send_pixel(input logic [7:0] d, input logic last, input int gap, input logic go);
        int n = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = last;
        load_go   = go;
        @(negedge clock);
        while (!pix_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!pix_ready) begin
            check("ready_timeout", 128'(pix_ready), 128'(1));
        end else begin
            px.push_back(d);
            xfer.push_back(cyc);
        end
        @(posedge clock); #1;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        load_go   = 1'b0;
        pix_data  = 8'($urandom);
        repeat (gap) begin
            @(posedge clock); #1;
        end
    endtask

    // Waits for load_done; optionally pulses load_go while the loader is in DONE.
    task automatic finish_frame(input logic go_in_done);
        int n = 0;
        while (!load_done && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!load_done) check("done_timeout", 128'(load_done), 128'(1));
        if (go_in_done) begin
            load_go = 1'b1;
            @(posedge clock); #1;
            load_go = 1'b0;
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic verify(input string nm);
        int n;
        int full;
        int nexp;
        logic partial;
        logic [127:0] w;
        int ecyc;
        n    = px.size();
        full = n / PPW;
        if (full > IMAGE_WORDS) full = IMAGE_WORDS;
        partial = (n % PPW != 0) && (n < NPIX);
        nexp = full + int'(partial);
        check({nm, "_nwrites"}, 128'(mon_addr.size()), 128'(nexp));
        for (int i = 0; i < mon_addr.size() && i < nexp; i++) begin
            w = '0;
            for (int k = 0; k < PPW; k++)
                if (i * PPW + k < n) w[k*8 +: 8] = px[i*PPW + k];
            ecyc = (i < full) ? xfer[i*PPW + PPW - 1] + 1 : xfer[n-1] + 2;
            check({nm, "_addr"}, 128'(mon_addr[i]), 128'(i));
            check({nm, "_data"}, mon_data[i], w);
            check({nm, "_wcyc"}, 128'(mon_cyc[i]), 128'(ecyc));
        end
        if (n == NPIX) begin
            check({nm, "_nstart"}, 128'(start_cyc.size()), 128'(1));
            if (start_cyc.size() == 1)
                check({nm, "_start_cyc"}, 128'(start_cyc[0]), 128'(xfer[n-1] + 2));
        end else begin
            check({nm, "_nstart"}, 128'(start_cyc.size()), 128'(0));
        end
        check({nm, "_load_done"}, 128'(load_done), 128'(1));
        check({nm, "_short"}, 128'(short_frame), 128'(n < NPIX));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int len;
        int nw;
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;

        // pix_valid in IDLE must not be accepted
        pix_valid = 1'b1;
        repeat (5) @(negedge clock);
        check("idle_ready", 128'(pix_ready), 128'(0));
        check("idle_nwrites", 128'(mon_addr.size()), 128'(0));
        @(posedge clock); #1;
        pix_valid = 1'b0;

        // A: full frame, back-to-back, value = index mod 256
        start_frame();
        for (int i = 0; i < NPIX; i++) send_pixel(8'(i), i == NPIX - 1, 0, 1'b0);
        finish_frame(1'b0);
        verify("A");
        if (mon_data.size() > 0)
            check("A_word0", mon_data[0], 128'h0F0E0D0C0B0A09080706050403020100);

        // B: same frame with pix_valid toggling every cycle
        start_frame();
        for (int i = 0; i < NPIX; i++) send_pixel(8'(i), i == NPIX - 1, 1, 1'b0);
        finish_frame(1'b0);
        verify("B");

        // C: 20-pixel short frame; load_go pulsed during DONE must be ignored
        start_frame();
        for (int i = 0; i < 20; i++) send_pixel(8'hAA, i == 19, 0, 1'b0);
        finish_frame(1'b1);
        verify("C");
        if (mon_data.size() > 1)
            check("C_word1", mon_data[1], 128'h000000000000000000000000AAAAAAAA);

        // D: short frame ending exactly on a word boundary
        start_frame();
        for (int i = 0; i < 32; i++) send_pixel(8'($urandom), i == 31, 0, 1'b0);
        finish_frame(1'b0);
        verify("D");

        // Randomised short frames with random gaps
        for (int f = 0; f < 3; f++) begin
            len = $urandom_range(1, 300);
            start_frame();
            for (int i = 0; i < len; i++)
                send_pixel(8'($urandom), i == len - 1, $urandom_range(0, 2), 1'b0);
            finish_frame(1'b0);
            verify("R");
        end

        // E: reset after 100 pixels
        start_frame();
        for (int i = 0; i < 100; i++) send_pixel(8'($urandom), 1'b0, 0, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_outputs_zero("midrst");
        nw = mon_addr.size();
        pix_valid = 1'b1;
        repeat (20) @(negedge clock);
        check("midrst_ready", 128'(pix_ready), 128'(0));
        check("midrst_nwrites", 128'(mon_addr.size()), 128'(nw));
        check("midrst_words", 128'(nw), 128'(100 / PPW));
        @(posedge clock); #1;
        pix_valid = 1'b0;

        // F: full random frame after the reset; load_go pulsed mid-LOAD
        start_frame();
        for (int i = 0; i < NPIX; i++)
            send_pixel(8'($urandom), i == NPIX - 1, 0, i == 5000);
        finish_frame(1'b0);
        verify("F");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/m1_image_loader.md
Name: m1_image_loader

Overview:
- Upstream stage of the histogram-equalisation accelerator.
- Accepts a raster stream of 8-bit pixels over a valid/ready interface and packs 16 pixels into each 128-bit word.
- Writes the packed words sequentially into input memory M1 from address 0.
- After the last word is written, pulses the accelerator start input; the accelerator then reads M1 via M1_ReadAddress1/M1_ReadBus1.

Parameters:
- PIXEL_W, 8, bits per pixel.
- PIXELS_PER_WORD, 16, pixels packed per M1 word (PIXEL_W*PIXELS_PER_WORD = 128).
- ADDR_W, 16, M1 address width.
- IMAGE_WORDS, 1024, words per frame (16384 pixels, 128x128 image).

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- load_go  input  1  one-cycle request to begin loading a frame; sampled only in IDLE.
- pix_valid  input  1  pixel present on pix_data.
- pix_data  input  8  pixel value.
- pix_last  input  1  marks final pixel of the frame; qualified by pix_valid.
- pix_ready  output  1  loader accepts a pixel this cycle.
- M1_WriteBus  output  128  packed pixel word.
- M1_WriteAddress  output  16  word address.
- M1_WriteEnable  output  1  write strobe, one cycle per word.
- accel_start  output  1  one-cycle start pulse to the accelerator.
- load_done  output  1  level; frame finished (success or error), held until next load_go.
- short_frame  output  1  level; pix_last arrived before IMAGE_WORDS*16 pixels; held until next load_go.

Behaviour:
- Reset (synchronous): state=IDLE; pix_ready, M1_WriteEnable, accel_start, load_done and short_frame = 0; M1_WriteBus=0; M1_WriteAddress=0; lane count=0; word count=0. Reset mid-frame abandons the frame with no further writes; the partially written M1 contents are don't-care.
- Handshake: a pixel transfers when pix_valid && pix_ready are both high on a rising edge. pix_ready=1 only in LOAD, with no stall. pix_data and pix_last are ignored when no transfer occurs.
- Packing: the pixel at lane k (0..15) occupies bits [8k+7:8k]; the first pixel of a word goes in bits [7:0].
- Write timing: on the cycle the 16th pixel of a word transfers, the word is registered. M1_WriteEnable=1 for exactly the next cycle, with M1_WriteAddress = word count (0-based). The word count increments after each write.
- Back-to-back pixels produce one write every 16 cycles. The lane register is reused immediately, so there are no bubbles.
- States:
  - IDLE: load_go=1 -> LOAD. Clears load_done, short_frame, and the lane and word counts. load_go is ignored in every other state.
  - LOAD: accepts pixels.
    - If the transfer completes word IMAGE_WORDS-1 -> WAIT.
    - If pix_last transfers earlier -> FLUSH.
    - pix_last on the final pixel of the final word is normal completion (-> WAIT). pix_last is ignored on other pixels only at exact frame end.
  - FLUSH:
    - If the lane count is nonzero, write the partial word with unused lanes zero, at the current word address, for one cycle.
    - If the pixel with pix_last completed a full word, that word's write is the flush and no extra write occurs.
    - Then -> DONE with short_frame=1 and no accel_start.
  - WAIT: the final M1 write is in flight (one cycle) -> START.
  - START: accel_start=1 for one cycle -> DONE.
  - DONE: load_done=1 -> IDLE on the next cycle. load_done is held through IDLE until the next load_go is accepted.
- Latency: accel_start asserts 2 cycles after the transfer of pixel 16383, i.e. 1 cycle after the final M1_WriteEnable.
- Arithmetic: the word count is ADDR_W bits and never wraps within a frame, since IMAGE_WORDS <= 2^ADDR_W. The lane count is 4 bits and wraps 15 -> 0 on word completion.
- M1_WriteBus and M1_WriteAddress hold their last values when M1_WriteEnable=0.

Test Plan:
- Reset, then load_go, then 16384 back-to-back pixels with value = index mod 256 and pix_last on the final pixel. Required: 1024 writes, addr 0..1023, one every 16 cycles; word 0 = 0x0F0E...0100; accel_start single pulse 1 cycle after the final write; load_done=1; short_frame=0.
- Same frame with pix_valid toggling 1/0 every cycle. Required: identical M1 contents; writes spaced 32 cycles apart; a single accel_start.
- Short frame: 20 pixels (value 0xAA), pix_last on the 20th. Required: write addr0 = all 0xAA; write addr1 = lanes 0-3 = 0xAA and the rest 0; short_frame=1; load_done=1; no accel_start.
- Short frame ending exactly on a word boundary (32 pixels, pix_last on the 32nd). Required: exactly 2 writes; short_frame=1; no extra zero write.
- Assert reset after 100 pixels. Required: all outputs 0 the next cycle and no further writes. A following load_go plus a full frame then completes normally from addr 0.
- load_go pulsed during LOAD and DONE. Required: ignored, with no restart or count reset; pix_valid during IDLE gives pix_ready=0 and no write.
